// File: rtl/serial_subtractor.sv
// serial_subtractor
//    Bit-serial full subtractor. Computes (A - B - Bin) mod 2^WIDTH, LSB first,
//    one bit per clock. It uses a single full-subtractor cell and a borrow
//    flip-flop.
//
//    Ports:
//       clk          system clock, rising edge
//       rst          synchronous active-high reset
//       start_valid  a_in/b_in/bin are valid
//       start_ready  block can accept a new operation (IDLE)
//       a_in, b_in   minuend / subtrahend, WIDTH bits
//       bin          borrow in
//       diff         result, (A - B - Bin) mod 2^WIDTH
//       bout         borrow out, 1 iff A < B + Bin (unsigned)
//       done_valid   diff/bout valid
//       done_ready   consumer takes the result
//       busy         high in RUN and DONE
//       ovf          signed overflow (only when SERSUB_OVF_EN is defined)
//
//    Optional feature macro: SERSUB_OVF_EN adds the ovf output.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
`ifdef SERSUB_OVF_EN
   output logic             ovf,
`endif
   output logic             done_valid,
   input  logic             done_ready,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] d_sr;
   logic [CW-1:0]    cnt;
   logic             br;

   // Full-subtractor cell on the current LSBs
   logic a0, b0, d, br_next;

   always_comb begin
      a0      = a_sr[0];
      b0      = b_sr[0];
      d       = a0 ^ b0 ^ br;
      br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a_sr        <= '0;
         b_sr        <= '0;
         d_sr        <= '0;
         cnt         <= '0;
         br          <= 1'b0;
         diff        <= '0;
         bout        <= 1'b0;
`ifdef SERSUB_OVF_EN
         ovf         <= 1'b0;
`endif
         done_valid  <= 1'b0;
         start_ready <= 1'b1;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_sr        <= a_in;
                  b_sr        <= b_in;
                  br          <= bin;
                  cnt         <= '0;
                  state       <= RUN;
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            RUN: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               d_sr <= {d, d_sr[WIDTH-1:1]};
               br   <= br_next;
               cnt  <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  // Final bit: publish the completed result in the same edge
                  diff       <= {d, d_sr[WIDTH-1:1]};
                  bout       <= br_next;
`ifdef SERSUB_OVF_EN
                  // a0/b0 now hold the operand MSBs, d is the result MSB
                  ovf        <= (a0 != b0) && (d != a0);
`endif
                  done_valid <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (done_ready) begin
                  done_valid  <= 1'b0;
                  start_ready <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               done_valid  <= 1'b0;
               start_ready <= 1'b1;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             bin;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             done_valid;
   logic             done_ready;
   logic             busy;
`ifdef SERSUB_OVF_EN
   logic             ovf;
`endif

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a_in        (a_in),
      .b_in        (b_in),
      .bin         (bin),
      .diff        (diff),
      .bout        (bout),
`ifdef SERSUB_OVF_EN
      .ovf         (ovf),
`endif
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] diff;
      logic             bout;
      logic             ovf;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic, unsigned for diff/bout, signed range for ovf
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c);
      exp_t e;
      int   full, sa, sb, ss;
      full   = int'(a) - int'(b) - int'(c);
      e.diff = full[WIDTH-1:0];
      e.bout = (full < 0);
      sa     = a[WIDTH-1] ? int'(a) - (1 << WIDTH) : int'(a);
      sb     = b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b);
      ss     = sa - sb - int'(c);
      e.ovf  = (ss < -(1 << (WIDTH-1))) || (ss > (1 << (WIDTH-1)) - 1);
      return e;
   endfunction

   // Monitor: consume one expectation per output handshake
   always @(negedge clk) begin
      if (!rst && done_valid && done_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("diff", 32'(diff), 32'(e.diff));
            chk("bout", 32'(bout), 32'(e.bout));
`ifdef SERSUB_OVF_EN
            chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (start_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (start_ready !== 1'b1) chk("start_ready_timeout", 32'(start_ready), 32'd1);
   endtask

   // Issue one operation; hold = cycles of done_ready=0 after done_valid,
   // spur = inject an ignored start pulse with fresh operands during RUN
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input int hold, input bit spur);
      exp_t e;
      int   lat;
      wait_ready();
      e           = model(a, b, c);
      done_ready  = (hold == 0);
      a_in        = a;
      b_in        = b;
      bin         = c;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      exp_q.push_back(e);
      lat = 0;
      for (int i = 1; i <= WIDTH + 4; i++) begin
         if (spur && i == 2) begin
            start_valid = 1'b1;
            a_in        = WIDTH'($urandom);
            b_in        = WIDTH'($urandom);
            bin         = ~c;
         end else begin
            start_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (done_valid === 1'b1) begin
            lat = i;
            break;
         end
         if (i == 3) chk("start_ready_run", 32'(start_ready), 32'd0);
      end
      start_valid = 1'b0;
      chk("latency", 32'(lat), 32'(WIDTH));
      chk("busy_done", 32'(busy), 32'd1);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(done_valid), 32'd1);
         chk("hold_ready", 32'(start_ready), 32'd0);
         chk("hold_diff", 32'(diff), 32'(e.diff));
         chk("hold_bout", 32'(bout), 32'(e.bout));
      end
      done_ready = 1'b1;
      @(posedge clk); #1;
      chk("idle_start_ready", 32'(start_ready), 32'd1);
      chk("idle_done_valid", 32'(done_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_diff_kept", 32'(diff), 32'(e.diff));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
      chk({tag, "_diff"}, 32'(diff), 32'd0);
      chk({tag, "_bout"}, 32'(bout), 32'd0);
      chk({tag, "_done_valid"}, 32'(done_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef SERSUB_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      start_valid = 1'b0;
      a_in        = '0;
      b_in        = '0;
      bin         = 1'b0;
      done_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_vals("reset");

      // Directed vectors
      do_op(8'h5A, 8'h23, 1'b0, 0, 1'b0);
      do_op(8'h00, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'h10, 8'h10, 1'b1, 0, 1'b0);
      do_op(8'h10, 8'h0F, 1'b1, 0, 1'b0);
      do_op(8'h37, 8'hC4, 1'b0, 5, 1'b1);
      do_op(8'h80, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'h7F, 8'hFF, 1'b0, 0, 1'b0);
      do_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
      do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);

      // Reset mid-RUN: discard operation
      wait_ready();
      a_in        = 8'hAA;
      b_in        = 8'h55;
      bin         = 1'b0;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_vals("midrun");
      for (int i = 0; i < WIDTH + 2; i++) begin
         @(posedge clk); #1;
         if (done_valid !== 1'b0) chk("no_done_after_reset", 32'(done_valid), 32'd0);
      end
      chk("queue_empty_after_reset", 32'(exp_q.size()), 32'd0);
      do_op(8'hAA, 8'h55, 1'b0, 0, 1'b0);

      // Randomized operations
      for (int n = 0; n < 40; n++) begin
         do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
               1'($urandom));
      end

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
